keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry.sv | 198 +++++++++++++++++++
 tb/tb_keypad_entry.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with debounce,
// release lockout and 4-digit BCD operand entry.
module keypad_entry #(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  fil_codigo,
   output logic [3:0]  col_codigo,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [15:0] num_out,
   output logic        num_full,
   output logic [1:0]  op_code,
   output logic        op_valid,
   output logic        enter
);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_EMIT,
      ST_RELEASE
   } state_t;

   state_t      state, state_n;
   logic [7:0]  dwell, dwell_n;
   logic [3:0]  deb_cnt, deb_cnt_n;
   logic [1:0]  col_idx, col_idx_n;
   logic [1:0]  row_idx, row_idx_n;
   logic [2:0]  dig_cnt, dig_cnt_n;
   logic [15:0] num_n;
   logic [3:0]  key_code_n;
   logic [1:0]  op_code_n;

   logic [3:0]  rows_low;
   logic        single;
   logic [1:0]  row_hit;
   logic        tick;
   logic        deb_done;
   logic        go_emit;
   logic [3:0]  hit_code;

   function automatic logic [3:0] key_map(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] code;
      case ({r, c})
         4'h0:    code = 4'd1;
         4'h1:    code = 4'd2;
         4'h2:    code = 4'd3;
         4'h3:    code = 4'd10;
         4'h4:    code = 4'd4;
         4'h5:    code = 4'd5;
         4'h6:    code = 4'd6;
         4'h7:    code = 4'd11;
         4'h8:    code = 4'd7;
         4'h9:    code = 4'd8;
         4'hA:    code = 4'd9;
         4'hB:    code = 4'd12;
         4'hC:    code = 4'd14;
         4'hD:    code = 4'd0;
         4'hE:    code = 4'd15;
         default: code = 4'd13;
      endcase
      return code;
   endfunction

   // Row sample decode: single-row detection and key lookup.
   always_comb begin
      rows_low = ~fil_codigo;
      single   = (rows_low != 4'd0) &&
                 ((rows_low & (rows_low - 4'd1)) == 4'd0);
      case (rows_low)
         4'b0010: row_hit = 2'd1;
         4'b0100: row_hit = 2'd2;
         4'b1000: row_hit = 2'd3;
         default: row_hit = 2'd0;
      endcase
      tick     = (dwell == 8'(SCAN_DIV - 1));
      deb_done = ({1'b0, deb_cnt} + 5'd1) >= 5'(DEBOUNCE);
      hit_code = key_map(row_hit, col_idx);
   end

   // Next state, scan position and entry action on acceptance.
   always_comb begin
      state_n    = state;
      dwell_n    = tick ? 8'd0 : dwell + 8'd1;
      deb_cnt_n  = deb_cnt;
      col_idx_n  = col_idx;
      row_idx_n  = row_idx;
      dig_cnt_n  = dig_cnt;
      num_n      = num_out;
      key_code_n = key_code;
      op_code_n  = op_code;
      go_emit    = 1'b0;
      case (state)
         ST_SCAN: begin
            if (tick) begin
               if (single) begin
                  row_idx_n = row_hit;
                  deb_cnt_n = 4'd1;
                  if (DEBOUNCE <= 1) go_emit = 1'b1;
                  else state_n = ST_DEBOUNCE;
               end else begin
                  col_idx_n = col_idx + 2'd1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (single && row_hit == row_idx) begin
                  deb_cnt_n = deb_cnt + 4'd1;
                  if (deb_done) go_emit = 1'b1;
               end else begin
                  state_n   = ST_SCAN;
                  col_idx_n = col_idx + 2'd1;
                  deb_cnt_n = 4'd0;
               end
            end
         end
         ST_EMIT: begin
            state_n   = ST_RELEASE;
            dwell_n   = 8'd0;
            deb_cnt_n = 4'd0;
         end
         ST_RELEASE: begin
            if (tick) begin
               if (rows_low == 4'd0) begin
                  if (deb_done) begin
                     state_n   = ST_SCAN;
                     col_idx_n = col_idx + 2'd1;
                     deb_cnt_n = 4'd0;
                  end else begin
                     deb_cnt_n = deb_cnt + 4'd1;
                  end
               end else begin
                  deb_cnt_n = 4'd0;
               end
            end
         end
         default: state_n = ST_SCAN;
      endcase
      if (go_emit) begin
         state_n    = ST_EMIT;
         key_code_n = hit_code;
         if (hit_code <= 4'd9) begin
            if (dig_cnt < 3'd4) begin
               num_n     = {num_out[11:0], hit_code};
               dig_cnt_n = dig_cnt + 3'd1;
            end
         end else if (hit_code == 4'd14) begin
            num_n     = 16'd0;
            dig_cnt_n = 3'd0;
         end else if (hit_code != 4'd15) begin
            op_code_n = 2'(hit_code - 4'd10);
         end
      end
   end

   // State and datapath registers; reset drops any pending key.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_SCAN;
         dwell    <= 8'd0;
         deb_cnt  <= 4'd0;
         col_idx  <= 2'd0;
         row_idx  <= 2'd0;
         dig_cnt  <= 3'd0;
         num_out  <= 16'd0;
         key_code <= 4'd0;
         op_code  <= 2'd0;
      end else begin
         state    <= state_n;
         dwell    <= dwell_n;
         deb_cnt  <= deb_cnt_n;
         col_idx  <= col_idx_n;
         row_idx  <= row_idx_n;
         dig_cnt  <= dig_cnt_n;
         num_out  <= num_n;
         key_code <= key_code_n;
         op_code  <= op_code_n;
      end
   end

   // Column drive and pulses; pulses exist only in EMIT.
   always_comb begin
      col_codigo = ~(4'b0001 << col_idx);
      key_valid  = (state == ST_EMIT);
      op_valid   = key_valid && key_code >= 4'd10 &&
                   key_code <= 4'd13;
      enter      = key_valid && key_code == 4'd15;
      num_full   = (dig_cnt == 3'd4);
   end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model driving keypad_entry,
// checked against a digit-queue reference model.
`timescale 1ns/1ps
module tb_keypad_entry;

   localparam int SD    = 4;
   localparam int DB    = 3;
   localparam int LIMIT = (DB + 6) * SD + 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  fil_codigo;
   logic [3:0]  col_codigo;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] num_out;
   logic        num_full;
   logic [1:0]  op_code;
   logic        op_valid;
   logic        enter;
   logic [15:0] pressed = 16'd0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk(clk), .reset(reset), .fil_codigo(fil_codigo),
      .col_codigo(col_codigo), .key_code(key_code),
      .key_valid(key_valid), .num_out(num_out),
      .num_full(num_full), .op_code(op_code),
      .op_valid(op_valid), .enter(enter)
   );

   // Physical matrix: a pressed key shorts its row to its
   // column, so the row reads low while that column is driven.
   function automatic logic [3:0] rows_seen(
      input logic [3:0] col, input logic [15:0] p
   );
      logic [3:0] f;
      f = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (p[r*4+c] && !col[c]) f[r] = 1'b0;
      return f;
   endfunction

   assign fil_codigo = rows_seen(col_codigo, pressed);

   string keys = "123A456B789C*0#D";

   function automatic int key_val(input int r, input int c);
      byte ch;
      ch = keys[r*4+c];
      if (ch >= "0" && ch <= "9") return ch - "0";
      if (ch >= "A" && ch <= "D") return ch - "A" + 10;
      if (ch == "*") return 14;
      return 15;
   endfunction

   function automatic logic [3:0] col_pat(input int c);
      logic [3:0] v;
      v = 4'b0001 << c[1:0];
      return ~v;
   endfunction

   // Reference: entered digits kept as a queue of numbers.
   int q[$];
   int ref_op = 0;

   function automatic int ref_num();
      int n;
      n = 0;
      foreach (q[i]) n = n * 16 + q[i];
      return n;
   endfunction

   task automatic model_key(input int k);
      if (k <= 9) begin
         if (q.size() < 4) q.push_back(k);
      end else if (k == 14) begin
         q.delete();
      end else if (k <= 13) begin
         ref_op = k - 10;
      end
   endtask

   task automatic model_reset();
      q.delete();
      ref_op = 0;
   endtask

   // Pulse monitor.
   int kv_cnt = 0;
   int op_cnt = 0;
   int en_cnt = 0;
   int stray  = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (key_valid) kv_cnt++;
         if (op_valid) op_cnt++;
         if (enter) en_cnt++;
         if ((op_valid || enter) && !key_valid) stray++;
      end
   end

   // Observations from the last do_key.
   logic        obs_seen;
   logic [3:0]  obs_code;
   logic [15:0] obs_num;
   logic        obs_full;
   logic [1:0]  obs_op;
   logic        obs_w1;
   int          obs_kv, obs_opp, obs_en;

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      pressed = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_key(input int r, input int c);
      int b_kv, b_op, b_en;
      b_kv = kv_cnt;
      b_op = op_cnt;
      b_en = en_cnt;
      obs_seen = 1'b0;
      obs_w1   = 1'b0;
      pressed[r*4+c] = 1'b1;
      for (int i = 0; i < LIMIT && !obs_seen; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (key_valid) begin
            obs_seen = 1'b1;
            obs_code = key_code;
            obs_num  = num_out;
            obs_full = num_full;
            obs_op   = op_code;
         end
      end
      if (obs_seen) begin
         @(posedge clk);
         @(negedge clk);
         obs_w1 = !key_valid;
      end
      repeat (3 * SD) @(posedge clk);
      @(negedge clk);
      pressed = 16'd0;
      repeat ((DB + 3) * SD) @(posedge clk);
      @(negedge clk);
      obs_kv  = kv_cnt - b_kv;
      obs_opp = op_cnt - b_op;
      obs_en  = en_cnt - b_en;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (col_codigo !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", col_codigo); end
      n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", key_code); end
      n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_kv: got %b want 0", key_valid); end
      n_vec++; if (num_out !== 16'h0) begin n_err++; $display("FAIL reset_num: got %h want 0000", num_out); end
      n_vec++; if (num_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", num_full); end
      n_vec++; if (op_code !== 2'd0) begin n_err++; $display("FAIL reset_op: got %0d want 0", op_code); end
      n_vec++; if (op_valid !== 1'b0 || enter !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got op_valid=%b enter=%b want 0 0", op_valid, enter); end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_single_key();
      int n, b_kv;
      logic hit;
      do_reset();
      for (int i = 0; i < 8 * SD && col_codigo == col_pat(1); i++) @(negedge clk);
      pressed[1*4+1] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 8 * SD && !hit; i++) begin
         @(negedge clk);
         hit = (col_codigo == col_pat(1));
      end
      n_vec++; if (!hit) begin n_err++; $display("FAIL single_col_wait: got col=%b want 1101 within budget", col_codigo); end
      b_kv = kv_cnt;
      n = 0;
      hit = 1'b0;
      while (n < LIMIT && !hit) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         hit = key_valid;
      end
      n_vec++; if (n != (SD - 1) + (DB - 1) * SD + 1 || !hit) begin n_err++; $display("FAIL single_latency: got %0d cycles (seen=%b) want %0d", n, hit, (SD - 1) + (DB - 1) * SD + 1); end
      n_vec++; if (key_code !== 4'd5) begin n_err++; $display("FAIL single_code: got %0d want 5", key_code); end
      n_vec++; if (num_out !== 16'h0005) begin n_err++; $display("FAIL single_num: got %h want 0005", num_out); end
      @(posedge clk);
      @(negedge clk);
      n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL single_width: got key_valid=%b want 0", key_valid); end
      repeat (4 * SD) @(posedge clk);
      @(negedge clk);
      pressed = 16'd0;
      repeat ((DB + 3) * SD) @(posedge clk);
      @(negedge clk);
      n_vec++; if (kv_cnt - b_kv != 1) begin n_err++; $display("FAIL single_count: got %0d pulses want 1", kv_cnt - b_kv); end
      model_key(5);
   endtask

   task automatic test_digits();
      int rr[5] = '{0, 0, 0, 1, 1};
      int cc[5] = '{0, 1, 2, 0, 1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_key(rr[i], cc[i]);
         model_key(key_val(rr[i], cc[i]));
         n_vec++; if (obs_kv != 1) begin n_err++; $display("FAIL digits_pulse%0d: got %0d want 1", i, obs_kv); end
         n_vec++; if (obs_num !== 16'(ref_num())) begin n_err++; $display("FAIL digits_num%0d: got %h want %h", i, obs_num, 16'(ref_num())); end
      end
      n_vec++; if (num_out !== 16'h1234) begin n_err++; $display("FAIL digits_final: got %h want 1234", num_out); end
      n_vec++; if (num_full !== 1'b1) begin n_err++; $display("FAIL digits_full: got %b want 1", num_full); end
   endtask

   task automatic test_short_press();
      int r, c, b_kv;
      logic hit;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      for (int i = 0; i < 8 * SD && col_codigo == col_pat(c); i++) @(negedge clk);
      b_kv = kv_cnt;
      pressed[r*4+c] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 8 * SD && !hit; i++) begin
         @(negedge clk);
         hit = (col_codigo == col_pat(c));
      end
      n_vec++; if (!hit) begin n_err++; $display("FAIL short_col_wait: got col=%b want %b", col_codigo, col_pat(c)); end
      repeat ((DB - 1) * SD) @(posedge clk);
      @(negedge clk);
      pressed = 16'd0;
      repeat (SD) @(posedge clk);
      @(negedge clk);
      n_vec++; if (col_codigo !== col_pat(c + 1)) begin n_err++; $display("FAIL short_next_col: got %b want %b", col_codigo, col_pat(c + 1)); end
      repeat (6 * SD) @(posedge clk);
      @(negedge clk);
      n_vec++; if (kv_cnt != b_kv) begin n_err++; $display("FAIL short_no_key: got %0d pulses want 0", kv_cnt - b_kv); end
   endtask

   task automatic test_multi_key();
      int c, b_kv, chg;
      logic [3:0] prev;
      c = $urandom_range(0, 3);
      b_kv = kv_cnt;
      @(negedge clk);
      pressed[0*4+c] = 1'b1;
      pressed[1*4+c] = 1'b1;
      prev = col_codigo;
      chg = 0;
      for (int i = 0; i < 8 * SD; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (col_codigo != prev) chg++;
         prev = col_codigo;
      end
      pressed = 16'd0;
      n_vec++; if (chg != 8) begin n_err++; $display("FAIL multi_rotate: got %0d column steps want 8", chg); end
      n_vec++; if (kv_cnt != b_kv) begin n_err++; $display("FAIL multi_no_key: got %0d pulses want 0", kv_cnt - b_kv); end
   endtask

   task automatic test_ops();
      do_reset();
      do_key(2, 0);
      n_vec++; if (obs_num !== 16'h0007 || obs_kv != 1) begin n_err++; $display("FAIL ops_seven: got num=%h pulses=%0d want 0007 1", obs_num, obs_kv); end
      do_key(3, 0);
      n_vec++; if (obs_num !== 16'h0000 || obs_full !== 1'b0) begin n_err++; $display("FAIL ops_star: got num=%h full=%b want 0000 0", obs_num, obs_full); end
      do_key(1, 3);
      n_vec++; if (obs_op !== 2'd1 || obs_opp != 1 || !obs_w1) begin n_err++; $display("FAIL ops_b: got op=%0d op_pulses=%0d w1=%b want 1 1 1", obs_op, obs_opp, obs_w1); end
      do_key(3, 2);
      n_vec++; if (obs_en != 1 || obs_num !== 16'h0000 || !obs_w1) begin n_err++; $display("FAIL ops_hash: got enter=%0d num=%h w1=%b want 1 0000 1", obs_en, obs_num, obs_w1); end
      model_reset();
   endtask

   task automatic test_reset_debounce();
      int b_kv;
      logic hit;
      do_reset();
      do_key(0, 0);
      for (int i = 0; i < 8 * SD && col_codigo == col_pat(2); i++) @(negedge clk);
      pressed[2*4+2] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 8 * SD && !hit; i++) begin
         @(negedge clk);
         hit = (col_codigo == col_pat(2));
      end
      n_vec++; if (!hit) begin n_err++; $display("FAIL rstdeb_col_wait: got %b want 1011", col_codigo); end
      b_kv = kv_cnt;
      repeat (SD + 2) @(posedge clk);
      @(negedge clk);
      reset   = 1'b1;
      pressed = 16'd0;
      @(posedge clk);
      @(negedge clk);
      n_vec++; if (col_codigo !== 4'b1110) begin n_err++; $display("FAIL rstdeb_col: got %b want 1110", col_codigo); end
      n_vec++; if (num_out !== 16'h0 || num_full !== 1'b0) begin n_err++; $display("FAIL rstdeb_num: got %h full=%b want 0000 0", num_out, num_full); end
      reset = 1'b0;
      model_reset();
      repeat (6 * SD) @(posedge clk);
      @(negedge clk);
      n_vec++; if (kv_cnt != b_kv) begin n_err++; $display("FAIL rstdeb_no_key: got %0d pulses want 0", kv_cnt - b_kv); end
   endtask

   task automatic test_random();
      int r, c, k;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         k = key_val(r, c);
         do_key(r, c);
         model_key(k);
         n_vec++; if (obs_kv != 1 || !obs_w1) begin n_err++; $display("FAIL rnd_pulse%0d: got %0d pulses w1=%b want 1 1", i, obs_kv, obs_w1); end
         n_vec++; if (obs_code !== 4'(k)) begin n_err++; $display("FAIL rnd_code%0d: got %0d want %0d", i, obs_code, k); end
         n_vec++; if (obs_num !== 16'(ref_num()) || obs_full !== (q.size() == 4)) begin n_err++; $display("FAIL rnd_num%0d: got %h full=%b want %h %b", i, obs_num, obs_full, 16'(ref_num()), q.size() == 4); end
         n_vec++; if (obs_op !== 2'(ref_op)) begin n_err++; $display("FAIL rnd_op%0d: got %0d want %0d", i, obs_op, ref_op); end
         n_vec++; if (obs_opp != ((k >= 10 && k <= 13) ? 1 : 0) || obs_en != ((k == 15) ? 1 : 0)) begin n_err++; $display("FAIL rnd_side%0d: got op=%0d en=%0d for key %0d", i, obs_opp, obs_en, k); end
      end
      n_vec++; if (stray != 0) begin n_err++; $display("FAIL stray_pulse: got %0d want 0", stray); end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_digits();
      test_short_press();
      test_multi_key();
      test_ops();
      test_reset_debounce();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
